// File: rtl/dmem_responder_if.sv
// Request/response bundle types and the core-facing interface
// for the data-memory responder.
package dmem_pkg;
   typedef struct packed {
      logic [31:0] write_data;
      logic        valid;
      logic        wen;
      logic        byte_not_word;
      logic        yumi;
   } mem_in_s;

   typedef struct packed {
      logic [31:0] read_data;
      logic        valid;
      logic        yumi;
   } mem_out_s;
endpackage

interface dmem_responder_if;
   import dmem_pkg::*;
   mem_in_s     to_mem_i;
   logic [31:0] addr_i;
   mem_out_s    from_mem_o;

   modport master (
      output to_mem_i,
      output addr_i,
      input  from_mem_o
   );

   modport slave (
      input  to_mem_i,
      input  addr_i,
      output from_mem_o
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed latency,
// response held until the core acknowledges with yumi.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned addr_width_p = 10,
   parameter int unsigned latency_p    = 1
) (
   input  logic            clk,
   input  logic            reset,
   dmem_responder_if.slave mem_if
);
   localparam int unsigned DepthLp = 2 ** addr_width_p;
   localparam logic [3:0]  LoadCnt = 4'(latency_p - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   state_e                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [addr_width_p-1:0] idx_q, idx_d;
   logic [1:0]              lane_q, lane_d;
   logic [31:0]             wdata_q, wdata_d;
   logic                    wen_q, wen_d;
   logic                    bnw_q, bnw_d;
   logic [31:0]             rdata_q, rdata_d;
   logic                    exec;
   logic [31:0]             word;
   logic [7:0]              sel_byte;
   logic [31:0]             mem_q [DepthLp];
   logic                    unused_addr;

   // Upper address bits alias: storage wraps modulo its byte size.
   assign unused_addr = ^mem_if.addr_i[31:addr_width_p+2];

   assign word     = mem_q[idx_q];
   assign sel_byte = word[{lane_q, 3'b000} +: 8];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      lane_d    = lane_q;
      wdata_d   = wdata_q;
      wen_d     = wen_q;
      bnw_d     = bnw_q;
      rdata_d   = rdata_q;
      exec      = 1'b0;
      mem_if.from_mem_o = '0;
      mem_if.from_mem_o.read_data = rdata_q;
      unique case (state_q)
         IDLE: begin
            mem_if.from_mem_o.yumi = mem_if.to_mem_i.valid & reset;
            if (mem_if.to_mem_i.valid) begin
               idx_d   = mem_if.addr_i[addr_width_p+1:2];
               lane_d  = mem_if.addr_i[1:0];
               wdata_d = mem_if.to_mem_i.write_data;
               wen_d   = mem_if.to_mem_i.wen;
               bnw_d   = mem_if.to_mem_i.byte_not_word;
               cnt_d   = LoadCnt;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               exec    = 1'b1;
               state_d = RESP;
               if (wen_q)      rdata_d = '0;
               else if (bnw_q) rdata_d = {24'b0, sel_byte};
               else            rdata_d = word;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            mem_if.from_mem_o.valid = 1'b1;
            if (mem_if.to_mem_i.yumi) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         lane_q  <= '0;
         wdata_q <= '0;
         wen_q   <= 1'b0;
         bnw_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         lane_q  <= lane_d;
         wdata_q <= wdata_d;
         wen_q   <= wen_d;
         bnw_q   <= bnw_d;
         rdata_q <= rdata_d;
      end
   end

   // Storage is never reset; exec is low whenever state is held in IDLE.
   always_ff @(posedge clk) begin
      if (exec && wen_q) begin
         if (bnw_q) mem_q[idx_q][{lane_q, 3'b000} +: 8] <= wdata_q[7:0];
         else       mem_q[idx_q] <= wdata_q;
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a
// byte-addressed reference memory.
module tb_dmem_responder;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   passed = 0;
   byte unsigned bmem [4096];

   dmem_responder_if b1 ();
   dmem_responder_if b4 ();

   dmem_responder #(.addr_width_p(10), .latency_p(1)) u_dut1 (
      .clk(clk), .reset(reset), .mem_if(b1)
   );
   dmem_responder #(.addr_width_p(10), .latency_p(4)) u_dut4 (
      .clk(clk), .reset(reset), .mem_if(b4)
   );

   always #5 clk = ~clk;

   // Reference: flat byte memory of 4096 bytes, little-endian lanes.
   task automatic mdl(input logic wen, input logic bw,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] exp);
      int ba;
      int base;
      ba   = int'(a % 32'd4096);
      base = ba - (ba % 4);
      exp  = '0;
      if (wen) begin
         if (bw) bmem[ba] = wd[7:0];
         else for (int i = 0; i < 4; i++) bmem[base+i] = wd[8*i +: 8];
      end else if (bw) begin
         exp = {24'b0, bmem[ba]};
      end else begin
         for (int i = 0; i < 4; i++) exp[8*i +: 8] = bmem[base+i];
      end
   endtask

   task automatic acc1(input logic wen, input logic bw,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic y0, output int lat,
                       output logic [31:0] rd, output logic drop,
                       output logic [31:0] exp);
      @(negedge clk);
      b1.addr_i = a;
      b1.to_mem_i.write_data = wd;
      b1.to_mem_i.wen = wen;
      b1.to_mem_i.byte_not_word = bw;
      b1.to_mem_i.yumi = 1'b0;
      b1.to_mem_i.valid = 1'b1;
      #1 y0 = b1.from_mem_o.yumi;
      @(posedge clk);
      #1 b1.to_mem_i.valid = 1'b0;
      lat = 0;
      while (!b1.from_mem_o.valid && lat < 40) begin
         @(posedge clk);
         #1 lat++;
      end
      rd = b1.from_mem_o.read_data;
      b1.to_mem_i.yumi = 1'b1;
      @(posedge clk);
      #1 b1.to_mem_i.yumi = 1'b0;
      drop = !b1.from_mem_o.valid;
      mdl(wen, bw, a, wd, exp);
   endtask

   task automatic test_reset();
      b1.to_mem_i.valid = 1'b1;
      repeat (2) @(negedge clk);
      #1 checks++;
      if (b1.from_mem_o !== '0 || b4.from_mem_o !== '0)
         $display("FAIL reset_out: got %h/%h required 0",
                  b1.from_mem_o, b4.from_mem_o);
      else passed++;
      b1.to_mem_i.valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_word();
      logic y0, dr;
      int lat;
      logic [31:0] rd, ex;
      acc1(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, y0, lat, rd, dr, ex);
      checks++;
      if (y0 !== 1'b1 || lat != 1 || rd !== 32'h0 || dr !== 1'b1)
         $display("FAIL word_store: y=%b lat=%0d rd=%h drop=%b required 1/1/0/1",
                  y0, lat, rd, dr);
      else passed++;
      acc1(1'b0, 1'b0, 32'h10, 32'h0, y0, lat, rd, dr, ex);
      checks++;
      if (y0 !== 1'b1 || lat != 1 || rd !== 32'hDEADBEEF || dr !== 1'b1)
         $display("FAIL word_load: y=%b lat=%0d rd=%h drop=%b required 1/1/deadbeef/1",
                  y0, lat, rd, dr);
      else passed++;
   endtask

   task automatic test_byte();
      logic y0, dr;
      int lat;
      logic [31:0] rd, ex;
      acc1(1'b1, 1'b0, 32'h10, 32'h11223344, y0, lat, rd, dr, ex);
      acc1(1'b1, 1'b1, 32'h13, 32'h5A5A5AAB, y0, lat, rd, dr, ex);
      checks++;
      if (rd !== 32'h0) $display("FAIL byte_store: got %h required 0", rd);
      else passed++;
      acc1(1'b0, 1'b0, 32'h10, 32'h0, y0, lat, rd, dr, ex);
      checks++;
      if (rd !== 32'hAB223344)
         $display("FAIL byte_merge: got %h required ab223344", rd);
      else passed++;
      acc1(1'b0, 1'b1, 32'h13, 32'h0, y0, lat, rd, dr, ex);
      checks++;
      if (rd !== 32'h000000AB)
         $display("FAIL byte_load3: got %h required 000000ab", rd);
      else passed++;
      acc1(1'b0, 1'b1, 32'h11, 32'h0, y0, lat, rd, dr, ex);
      checks++;
      if (rd !== 32'h00000033)
         $display("FAIL byte_load1: got %h required 00000033", rd);
      else passed++;
   endtask

   task automatic test_wrap();
      logic y0, dr;
      int lat;
      logic [31:0] rd, ex, d;
      d = $urandom;
      acc1(1'b1, 1'b0, 32'h1004, d, y0, lat, rd, dr, ex);
      acc1(1'b0, 1'b0, 32'h4, 32'h0, y0, lat, rd, dr, ex);
      checks++;
      if (rd !== d) $display("FAIL wrap: got %h required %h", rd, d);
      else passed++;
   endtask

   task automatic test_reset_mid();
      logic y0, dr;
      int lat;
      logic [31:0] rd, ex;
      acc1(1'b1, 1'b0, 32'h20, 32'h5, y0, lat, rd, dr, ex);
      acc1(1'b0, 1'b0, 32'h20, 32'h0, y0, lat, rd, dr, ex);
      @(negedge clk);
      b1.addr_i = 32'h20;
      b1.to_mem_i.write_data = 32'hCAFEF00D;
      b1.to_mem_i.wen = 1'b1;
      b1.to_mem_i.byte_not_word = 1'b0;
      b1.to_mem_i.valid = 1'b1;
      @(posedge clk);
      #1 b1.to_mem_i.valid = 1'b0;
      reset = 1'b0;
      #1 checks++;
      if (b1.from_mem_o !== '0)
         $display("FAIL reset_mid_out: got %h required 0", b1.from_mem_o);
      else passed++;
      @(negedge clk);
      reset = 1'b1;
      acc1(1'b0, 1'b0, 32'h20, 32'h0, y0, lat, rd, dr, ex);
      checks++;
      if (rd !== 32'h5 || lat != 1)
         $display("FAIL reset_mid_load: rd=%h lat=%0d required 5/1", rd, lat);
      else passed++;
   endtask

   task automatic test_latency();
      int lat;
      logic ok;
      logic [31:0] held;
      @(negedge clk);
      b4.addr_i = 32'h40;
      b4.to_mem_i.write_data = 32'h12345678;
      b4.to_mem_i.wen = 1'b1;
      b4.to_mem_i.byte_not_word = 1'b0;
      b4.to_mem_i.yumi = 1'b0;
      b4.to_mem_i.valid = 1'b1;
      #1 checks++;
      if (b4.from_mem_o.yumi !== 1'b1)
         $display("FAIL lat_accept: got %b required 1", b4.from_mem_o.yumi);
      else passed++;
      @(posedge clk);
      ok = 1'b1;
      for (lat = 0; lat < 40; lat++) begin
         #1;
         if (b4.from_mem_o.valid) break;
         if (b4.from_mem_o.yumi) ok = 1'b0;
         b4.addr_i = $urandom;
         b4.to_mem_i.write_data = $urandom;
         b4.to_mem_i.wen = 1'($urandom);
         b4.to_mem_i.byte_not_word = 1'($urandom);
         @(posedge clk);
      end
      checks++;
      if (lat != 4 || !ok || b4.from_mem_o.read_data !== 32'h0)
         $display("FAIL lat_store: lat=%0d noacc=%b rd=%h required 4/1/0",
                  lat, ok, b4.from_mem_o.read_data);
      else passed++;
      b4.addr_i = 32'h40;
      b4.to_mem_i.wen = 1'b0;
      b4.to_mem_i.byte_not_word = 1'b0;
      b4.to_mem_i.yumi = 1'b1;
      #1 checks++;
      if (b4.from_mem_o.yumi !== 1'b0 || b4.from_mem_o.valid !== 1'b1)
         $display("FAIL lat_resp_noacc: y=%b v=%b required 0/1",
                  b4.from_mem_o.yumi, b4.from_mem_o.valid);
      else passed++;
      @(posedge clk);
      #1 b4.to_mem_i.yumi = 1'b0;
      checks++;
      if (b4.from_mem_o.yumi !== 1'b1 || b4.from_mem_o.valid !== 1'b0)
         $display("FAIL lat_next_accept: y=%b v=%b required 1/0",
                  b4.from_mem_o.yumi, b4.from_mem_o.valid);
      else passed++;
      @(posedge clk);
      for (lat = 0; lat < 40; lat++) begin
         #1 b4.to_mem_i.valid = 1'b0;
         if (b4.from_mem_o.valid) break;
         @(posedge clk);
      end
      held = b4.from_mem_o.read_data;
      checks++;
      if (lat != 4 || held !== 32'h12345678)
         $display("FAIL lat_load: lat=%0d rd=%h required 4/12345678", lat, held);
      else passed++;
      ok = 1'b1;
      for (int k = 0; k < 3; k++) begin
         b4.to_mem_i.valid = 1'b1;
         b4.addr_i = $urandom;
         @(posedge clk);
         #1;
         if (!b4.from_mem_o.valid || b4.from_mem_o.yumi ||
             b4.from_mem_o.read_data !== held) ok = 1'b0;
      end
      checks++;
      if (!ok) $display("FAIL lat_hold: rd=%h required %h stable",
                        b4.from_mem_o.read_data, held);
      else passed++;
      b4.to_mem_i.valid = 1'b0;
      b4.to_mem_i.yumi = 1'b1;
      @(posedge clk);
      #1 b4.to_mem_i.yumi = 1'b0;
      checks++;
      if (b4.from_mem_o.valid !== 1'b0)
         $display("FAIL lat_ack: valid=%b required 0", b4.from_mem_o.valid);
      else passed++;
   endtask

   task automatic test_ignore();
      int resp;
      b1.to_mem_i.yumi = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      b1.addr_i = 32'h10;
      b1.to_mem_i.wen = 1'b0;
      b1.to_mem_i.byte_not_word = 1'b0;
      b1.to_mem_i.valid = 1'b1;
      @(posedge clk);
      #1 checks++;
      if (b1.from_mem_o.valid !== 1'b0 || b1.from_mem_o.yumi !== 1'b0)
         $display("FAIL ign_wait: v=%b y=%b required 0/0",
                  b1.from_mem_o.valid, b1.from_mem_o.yumi);
      else passed++;
      @(posedge clk);
      #1 b1.to_mem_i.yumi = 1'b0;
      resp = 0;
      for (int k = 0; k < 3; k++) begin
         if (b1.from_mem_o.valid && !b1.from_mem_o.yumi) resp++;
         @(posedge clk);
         #1;
      end
      checks++;
      if (resp != 3 || b1.from_mem_o.read_data !== 32'hAB223344)
         $display("FAIL ign_resp: held=%0d rd=%h required 3/ab223344",
                  resp, b1.from_mem_o.read_data);
      else passed++;
      b1.to_mem_i.valid = 1'b0;
      b1.to_mem_i.yumi = 1'b1;
      @(posedge clk);
      #1 b1.to_mem_i.yumi = 1'b0;
      resp = 0;
      for (int k = 0; k < 4; k++) begin
         if (b1.from_mem_o.valid) resp++;
         @(posedge clk);
         #1;
      end
      checks++;
      if (resp != 0) $display("FAIL ign_extra: got %0d responses required 0", resp);
      else passed++;
   endtask

   task automatic test_random();
      logic y0, dr, wen, bw;
      int lat;
      logic [31:0] rd, ex, a, r;
      for (int i = 0; i < 16; i++)
         acc1(1'b1, 1'b0, 32'(i * 4), $urandom, y0, lat, rd, dr, ex);
      for (int i = 0; i < 60; i++) begin
         r   = $urandom;
         a   = (r & 32'hFFFF_F000) | 32'($urandom_range(0, 15) * 4)
             | 32'($urandom_range(0, 3));
         wen = 1'($urandom);
         bw  = 1'($urandom);
         acc1(wen, bw, a, $urandom, y0, lat, rd, dr, ex);
         checks++;
         if (y0 !== 1'b1 || lat != 1 || rd !== ex || dr !== 1'b1)
            $display("FAIL rand%0d a=%h w=%b b=%b: y=%b lat=%0d rd=%h drop=%b required 1/1/%h/1",
                     i, a, wen, bw, y0, lat, rd, dr, ex);
         else passed++;
      end
   endtask

   initial begin
      b1.to_mem_i = '0;
      b1.addr_i   = '0;
      b4.to_mem_i = '0;
      b4.addr_i   = '0;
      test_reset();
      test_word();
      test_byte();
      test_wrap();
      test_ignore();
      test_reset_mid();
      test_latency();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
